// File: rtl/ahb_prior_scheduler.sv
// Aging priority scheduler for the AHB dynamic-priority arbiter: tracks each master's
// request/wait/ownership state and boosts the priority of masters left waiting.
module ahb_prior_scheduler #(
    parameter int MASTER_NUM    = 4,
    parameter int PRIOR_BIT     = 2,
    parameter int AGE_BIT       = 6,
    parameter int AGE_STEP_LOG2 = 3,
    parameter int STARVE_LIMIT  = 24
) (
    input  logic                            hclk,
    input  logic                            hreset_n,
    input  logic [MASTER_NUM-1:0]           hreq,
    input  logic [MASTER_NUM-1:0]           hgrant,
    input  logic [MASTER_NUM-1:0]           hlast,
    input  logic                            hwait,
    input  logic                            cfg_we,
    input  logic [$clog2(MASTER_NUM)-1:0]   cfg_idx,
    input  logic [PRIOR_BIT-1:0]            cfg_prior,
    output logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
    output logic [MASTER_NUM-1:0]           starve
);

    localparam int SUM_W = PRIOR_BIT + AGE_BIT;
    localparam logic [PRIOR_BIT-1:0] PMAX = '1;
    localparam logic [AGE_BIT-1:0]   STARVE_AGE = AGE_BIT'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OWN
    } state_e;

    state_e               st_q   [MASTER_NUM];
    logic [AGE_BIT-1:0]   age_q  [MASTER_NUM];
    logic [PRIOR_BIT-1:0] base_q [MASTER_NUM];

    // hgrant is already masked by the slave wait, so hwait carries no extra information.
    logic        hwait_unused;
    logic [31:0] cfg_idx_ext;

    assign hwait_unused = hwait;
    assign cfg_idx_ext  = 32'(cfg_idx);

    // NOTE: state registers use non-blocking assignments so every master sees the
    // pre-edge values; the small per-master arrays are real flops and get a reset value.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            for (int i = 0; i < MASTER_NUM; i++) begin
                st_q[i]   <= ST_IDLE;
                age_q[i]  <= '0;
                base_q[i] <= PRIOR_BIT'(i);
            end
        end else begin
            for (int i = 0; i < MASTER_NUM; i++) begin
                // An out-of-range index never matches any master, so it is dropped.
                if (cfg_we && (cfg_idx_ext == 32'(i))) begin
                    base_q[i] <= cfg_prior;
                end

                if (hgrant[i] && hlast[i]) begin
                    st_q[i]  <= ST_IDLE;
                    age_q[i] <= '0;
                end else begin
                    unique case (st_q[i])
                        ST_IDLE: begin
                            if (hgrant[i]) begin
                                st_q[i]  <= ST_OWN;
                                age_q[i] <= '0;
                            end else if (hreq[i]) begin
                                st_q[i]  <= ST_WAIT;
                                age_q[i] <= AGE_BIT'(1);
                            end
                        end
                        ST_WAIT: begin
                            if (hgrant[i]) begin
                                st_q[i]  <= ST_OWN;
                                age_q[i] <= '0;
                            end else if (hreq[i]) begin
                                if (age_q[i] != '1) begin
                                    age_q[i] <= age_q[i] + 1'b1;
                                end
                            end else begin
                                st_q[i]  <= ST_IDLE;
                                age_q[i] <= '0;
                            end
                        end
                        ST_OWN: begin
                            age_q[i] <= '0;
                        end
                        default: begin
                            st_q[i]  <= ST_IDLE;
                            age_q[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Outputs depend on registers only, so reset reaches them without a clock.
    always_comb begin
        logic [SUM_W-1:0] sum;
        // NOTE: every output is given a default first so no path can infer a latch.
        hprior = '0;
        starve = '0;
        sum    = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            starve[i] = (age_q[i] >= STARVE_AGE);
            sum = SUM_W'(base_q[i]) + SUM_W'(age_q[i] >> AGE_STEP_LOG2);
            if (starve[i] || (sum > SUM_W'(PMAX))) begin
                hprior[i*PRIOR_BIT +: PRIOR_BIT] = PMAX;
            end else begin
                hprior[i*PRIOR_BIT +: PRIOR_BIT] = sum[PRIOR_BIT-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ahb_prior_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a random
// phase compared every cycle against a behavioural model of the aging rules.
module tb_ahb_prior_scheduler;

    localparam int N     = 4;
    localparam int PB    = 2;
    localparam int PMAX  = 3;
    localparam int AMAX  = 63;
    localparam int STEP  = 8;
    localparam int LIMIT = 24;

    logic          hclk;
    logic          hreset_n;
    logic [N-1:0]  hreq;
    logic [N-1:0]  hgrant;
    logic [N-1:0]  hlast;
    logic          hwait;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic [PB-1:0] cfg_prior;
    logic [N*PB-1:0] hprior;
    logic [N-1:0]  starve;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // Model: 0 = idle, 1 = waiting, 2 = owning the bus.
    int m_st   [N];
    int m_age  [N];
    int m_base [N];

    ahb_prior_scheduler dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .hreq      (hreq),
        .hgrant    (hgrant),
        .hlast     (hlast),
        .hwait     (hwait),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_prior (cfg_prior),
        .hprior    (hprior),
        .starve    (starve)
    );

    initial hclk = 0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int exp_prior(input int i);
        int s;
        if (m_age[i] >= LIMIT) return PMAX;
        s = m_base[i] + m_age[i] / STEP;
        return (s > PMAX) ? PMAX : s;
    endfunction

    always @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            for (int i = 0; i < N; i++) begin
                m_st[i]   <= 0;
                m_age[i]  <= 0;
                m_base[i] <= i % 4;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cfg_we && (int'(cfg_idx) == i)) m_base[i] <= int'(cfg_prior);
                if (hgrant[i] && hlast[i]) begin
                    m_st[i] <= 0; m_age[i] <= 0;
                end else if (hgrant[i] && m_st[i] != 2) begin
                    m_st[i] <= 2; m_age[i] <= 0;
                end else if (m_st[i] == 0 && hreq[i]) begin
                    m_st[i] <= 1; m_age[i] <= 1;
                end else if (m_st[i] == 1 && hreq[i]) begin
                    m_age[i] <= (m_age[i] + 1 > AMAX) ? AMAX : m_age[i] + 1;
                end else if (m_st[i] == 1) begin
                    m_st[i] <= 0; m_age[i] <= 0;
                end else if (m_st[i] == 2) begin
                    m_age[i] <= 0;
                end
            end
        end
    end

    always @(negedge hclk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("model_hprior[%0d]", i), int'(hprior[i*PB +: PB]), exp_prior(i));
                check($sformatf("model_starve[%0d]", i), int'(starve[i]), (m_age[i] >= LIMIT) ? 1 : 0);
            end
        end
    end

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] gnt, input logic [N-1:0] last,
                         input logic we, input logic [1:0] idx, input logic [PB-1:0] pr);
        @(negedge hclk);
        hreq = req; hgrant = gnt; hlast = last; hwait = (gnt == '0) && (req != '0);
        cfg_we = we; cfg_idx = idx; cfg_prior = pr;
    endtask

    task automatic idle_inputs();
        hreq = '0; hgrant = '0; hlast = '0; hwait = 0;
        cfg_we = 0; cfg_idx = '0; cfg_prior = '0;
    endtask

    task automatic do_reset();
        @(negedge hclk);
        #2 hreset_n = 0;
        idle_inputs();
        @(negedge hclk);
        @(negedge hclk);
        hreset_n = 1;
    endtask

    task automatic settle();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset_n = 1;
        idle_inputs();
        #3 hreset_n = 0;
        #1;
        // Reset values.
        check("reset_hprior", int'(hprior), 'hE4);
        check("reset_starve", int'(starve), 0);
        @(negedge hclk);
        @(negedge hclk);
        hreset_n = 1;
        chk_en = 1;
        repeat (3) drive('0, '0, '0, 0, 0, 0);
        settle();
        check("idle_hprior", int'(hprior), 'hE4);
        check("idle_starve", int'(starve), 0);

        // Aging of master 0 up to saturation.
        repeat (8) drive(4'b0001, '0, '0, 0, 0, 0);
        settle();
        check("age8_hprior0", int'(hprior[1:0]), 1);
        repeat (8) drive(4'b0001, '0, '0, 0, 0, 0);
        settle();
        check("age16_hprior0", int'(hprior[1:0]), 2);
        check("age16_starve0", int'(starve[0]), 0);
        repeat (8) drive(4'b0001, '0, '0, 0, 0, 0);
        settle();
        check("age24_hprior0", int'(hprior[1:0]), 3);
        check("age24_starve0", int'(starve[0]), 1);
        repeat (50) drive(4'b0001, '0, '0, 0, 0, 0);
        settle();
        check("sat_hprior0", int'(hprior[1:0]), 3);
        check("sat_starve0", int'(starve[0]), 1);

        // Ownership across hwait cycles.
        do_reset();
        repeat (10) drive(4'b0001, '0, '0, 0, 0, 0);
        settle();
        check("wait10_hprior0", int'(hprior[1:0]), 1);
        drive(4'b0001, 4'b0001, '0, 0, 0, 0);
        settle();
        check("own_hprior0", int'(hprior[1:0]), 0);
        repeat (5) drive(4'b0001, '0, '0, 0, 0, 0);
        settle();
        check("own_hwait_hprior0", int'(hprior[1:0]), 0);
        drive(4'b0001, 4'b0001, 4'b0001, 0, 0, 0);
        settle();
        check("own_end_hprior0", int'(hprior[1:0]), 0);
        check("own_end_starve0", int'(starve[0]), 0);
        repeat (8) drive(4'b0001, '0, '0, 0, 0, 0);
        settle();
        check("rewait_hprior0", int'(hprior[1:0]), 1);

        // Config write and clipping.
        do_reset();
        drive('0, '0, '0, 1, 2'd1, 2'd0);
        settle();
        check("cfg_hprior1", int'(hprior[3:2]), 0);
        repeat (15) drive(4'b0100, '0, '0, 0, 0, 0);
        drive(4'b0100, '0, '0, 1, 2'd2, 2'd2);
        settle();
        check("cfg_clip_hprior2", int'(hprior[5:4]), 3);
        check("cfg_clip_starve2", int'(starve[2]), 0);

        // Request withdrawal.
        do_reset();
        repeat (12) drive(4'b0010, '0, '0, 0, 0, 0);
        settle();
        check("wd_wait_hprior1", int'(hprior[3:2]), 2);
        drive('0, '0, '0, 0, 0, 0);
        settle();
        check("wd_idle_hprior1", int'(hprior[3:2]), 1);
        check("wd_idle_starve1", int'(starve[1]), 0);

        // Asynchronous reset in the middle of a starving wait.
        do_reset();
        repeat (30) drive(4'b1000, '0, '0, 0, 0, 0);
        settle();
        check("pre_rst_starve3", int'(starve[3]), 1);
        check("pre_rst_hprior3", int'(hprior[7:6]), 3);
        @(negedge hclk);
        #2 hreset_n = 0;
        #1;
        check("async_rst_starve", int'(starve), 0);
        check("async_rst_hprior", int'(hprior), 'hE4);
        idle_inputs();
        @(negedge hclk);
        hreset_n = 1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] req;
            logic [N-1:0] gnt;
            int r;
            req = '0;
            for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 99) < 85);
            r = $urandom_range(0, 99);
            if (r < 70)      gnt = '0;
            else if (r < 96) gnt = N'(1) << $urandom_range(0, N-1);
            else             gnt = N'($urandom_range(0, 15));
            drive(req, gnt, N'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                  2'($urandom_range(0, 3)), PB'($urandom_range(0, 3)));
        end
        @(negedge hclk);
        chk_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_prior_scheduler.md
# ahb_prior_scheduler

Aging-based priority scheduler for the AHB dynamic-priority arbiter. Per master, it tracks request, wait and ownership state and drives the arbiter's `hprior` vector. A master's priority is its programmable base priority plus an age boost earned while it waits ungranted. Masters waiting past a threshold are forced to maximum priority and flagged as starving. It sits beside each slave-port arbiter: it observes `hreq`/`hgrant`/`hlast`/`hwait` and feeds `hprior` back.

## Interface
- `MASTER_NUM`, 4, number of masters on this slave port.
- `PRIOR_BIT`, 2, width of each `hprior` entry; maximum priority is PMAX = 2^PRIOR_BIT-1.
- `AGE_BIT`, 6, width of each age counter; saturates at AMAX = 2^AGE_BIT-1.
- `AGE_STEP_LOG2`, 3, wait cycles per +1 boost = 2^AGE_STEP_LOG2.
- `STARVE_LIMIT`, 24, age at which a master is starving; legal range 1..AMAX.
- `hclk`  in  1  clock.
- `hreset_n`  in  1  reset, asynchronous, active-low.
- `hreq`  in  MASTER_NUM  per-master request.
- `hgrant`  in  MASTER_NUM  arbiter grant, already masked by `hwait`, one-hot or zero.
- `hlast`  in  MASTER_NUM  per-master last-transfer-of-transaction.
- `hwait`  in  1  slave wait; informational only, since `hgrant` is already masked.
- `cfg_we`  in  1  base-priority write strobe.
- `cfg_idx`  in  $clog2(MASTER_NUM)  master index for the write.
- `cfg_prior`  in  PRIOR_BIT  new base priority.
- `hprior`  out  MASTER_NUM x PRIOR_BIT  packed priority per master, to the arbiter.
- `starve`  out  MASTER_NUM  master is at or above STARVE_LIMIT.

## Operation
- **Per-master registers:**
  - `base[i]`, PRIOR_BIT bits.
  - `age[i]`, AGE_BIT bits.
  - `st[i]` in {IDLE, WAIT, OWN}.
- **FSM transitions per master i** (evaluated every edge, first match wins):
  - Any state, `hgrant[i] & hlast[i]`: next state IDLE, age cleared. This covers single-transfer transactions.
  - IDLE or WAIT, `hgrant[i] & ~hlast[i]`: next state OWN, age cleared.
  - IDLE, `hreq[i] & ~hgrant[i]`: next state WAIT, age = 1.
  - WAIT, `hreq[i] & ~hgrant[i]`: stay in WAIT, age = min(age+1, AMAX).
  - WAIT, `~hreq[i]`: next state IDLE, age cleared.
  - OWN, otherwise: stay in OWN, age held at 0. This includes `hwait` cycles where `hgrant[i]` = 0.
- **Config write:** `cfg_we` loads `base[cfg_idx]` <= `cfg_prior`. Indices >= MASTER_NUM are ignored. Aging is not affected.
- **Priority output:**
  - boost = age >> AGE_STEP_LOG2.
  - sum = base + boost, computed at PRIOR_BIT+AGE_BIT width with no overflow.
  - `hprior[i]` = PMAX if `starve[i]`, else min(sum, PMAX).
- **Starvation:** `starve[i]` = (age >= STARVE_LIMIT). It is only reachable in WAIT.
- **Grant policy:**
  - An ungranted master's age keeps counting while another master is in OWN.
  - At the next arbitration the older master wins by priority. Ties resolve in the arbiter (higher index wins).
- **Illegal input:** more than one `hgrant` bit set is illegal input; each master still follows its own FSM independently.

## Timing
- **Reset** (asynchronous, immediate on `hreset_n` falling edge):
  - `base[i]` = i mod 2^PRIOR_BIT.
  - `age` = 0, `st` = IDLE.
  - Outputs: `hprior[i]` = i mod 2^PRIOR_BIT, `starve` = 0.
- **Output latency:**
  - `hprior` and `starve` are combinational functions of registers only. There is no combinational path from any input.
  - An input sampled at edge k is reflected in the outputs after edge k (1-cycle latency).
- **Simultaneous events:**
  - A config write and aging at the same edge both apply; the output uses the new base plus the updated age.
  - A grant and a config write at the same edge both apply.
- **Saturation:** age stops at AMAX. `hprior` stays at PMAX and `starve` stays 1 while the master remains in WAIT.
- **Reset mid-operation:** reset aborts any WAIT or OWN. Outputs return to reset values within the same cycle and do not wait for a clock.

## Test plan
Defaults: MASTER_NUM=4, PRIOR_BIT=2, AGE_STEP_LOG2=3, STARVE_LIMIT=24, AGE_BIT=6.
1. **Reset:** assert `hreset_n`=0 → `hprior` = {3,2,1,0} (index 3..0), `starve` = 0000; values hold after release with no requests.
2. **Aging:** hold `hreq[0]`=1, `hgrant`=0 → `hprior[0]` = 1 after 8 edges, 2 after 16, 3 with `starve[0]`=1 after 24; age saturates at 63 and outputs stay 3/1.
3. **Ownership with waits:** `hreq[0]` waits 10 cycles, then `hgrant[0]`=1, `hlast[0]`=0 for 1 cycle; then `hgrant`=0 for 5 `hwait` cycles; then `hgrant[0]`=1, `hlast[0]`=1 → age is 0 and `hprior[0]`=0 throughout OWN; state goes IDLE and, with `hreq` still high, back to WAIT next edge.
4. **Config and saturation:** write `cfg_idx`=1, `cfg_prior`=0 → `hprior[1]`=0 next cycle; write `cfg_idx`=2, `cfg_prior`=2 with master 2 at age 16 → `hprior[2]`=3 (clipped), `starve[2]`=0.
5. **Request withdrawal:** master 1 in WAIT at age 12 drops `hreq` → IDLE next edge, age 0, `hprior[1]` = base.
6. **Reset mid-operation:** master 3 at age 30 with `starve[3]`=1 → pull `hreset_n` low between edges; `starve`=0 and `hprior[3]`=3 (base) asynchronously, before the next clock edge.
